// File: rtl/program_sequencer.sv
// Program-address sequencer: increment, skip, jump, call/return with a circular
// return-address stack that keeps the newest STACK_DEPTH entries, plus sticky stack-error flags.
module program_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             advance,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             skip,
  input  logic [ADDR_WIDTH-1:0]            target,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];
  logic [PW-1:0]         wr_ptr_r;

  logic [ADDR_WIDTH-1:0] pc_s;
  logic [DW-1:0]         depth_s;
  logic                  overflow_s;
  logic                  underflow_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;
  logic [PW-1:0]         top_ptr_s;

  // wr_ptr_r names the next slot to write; it wraps explicitly so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(STACK_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == PW'(0)) ? PW'(STACK_DEPTH - 1) : p - PW'(1);
  endfunction

  assign pc_inc_s  = pc + ADDR_WIDTH'(1);
  assign top_ptr_s = ptr_dec(wr_ptr_r);

  // Next-state selection with fixed priority ret > call > jump > skip > increment.
  always_comb begin
    pc_s        = pc;
    depth_s     = depth;
    overflow_s  = overflow;
    underflow_s = underflow;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (advance) begin
      if (ret) begin
        if (depth != DW'(0)) begin
          pop_s   = 1'b1;
          pc_s    = stack_r[top_ptr_s];
          depth_s = depth - DW'(1);
        end else begin
          pc_s        = pc_inc_s;
          underflow_s = 1'b1;
        end
      end else if (call) begin
        push_s = 1'b1;
        pc_s   = target;
        // A full stack overwrites its oldest entry, which is the slot wr_ptr_r points at.
        if (depth == DW'(STACK_DEPTH)) begin
          overflow_s = 1'b1;
        end else begin
          depth_s = depth + DW'(1);
        end
      end else if (jump) begin
        pc_s = target;
      end else if (skip) begin
        pc_s = pc + ADDR_WIDTH'(2);
      end else begin
        pc_s = pc_inc_s;
      end
    end else begin
      pc_s = pc;
    end
  end

  // State registers; synchronous reset clears everything except stack contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= ADDR_WIDTH'(RESET_ADDR);
      depth     <= DW'(0);
      overflow  <= 1'b0;
      underflow <= 1'b0;
      wr_ptr_r  <= PW'(0);
    end else begin
      pc        <= pc_s;
      depth     <= depth_s;
      overflow  <= overflow_s;
      underflow <= underflow_s;
      if (push_s) begin
        stack_r[wr_ptr_r] <= pc_inc_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end else if (pop_s) begin
        wr_ptr_r <= top_ptr_s;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed plus random bench for program_sequencer against a queue-based reference model.
module tb_program_sequencer;

  localparam int AW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          advance = 1'b0;
  logic          jump = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic          skip = 1'b0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] depth;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers and a queue of return addresses, newest at the back.
  int m_pc  = 0;
  int m_stack[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  program_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .advance(advance), .jump(jump), .call(call),
    .ret(ret), .skip(skip), .target(target), .pc(pc), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".depth"}, 32'(depth), 32'(m_stack.size()));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; advance = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_model("reset");
  endtask

  task automatic step(input string tag, input bit a, input bit r, input bit c,
                      input bit j, input bit s, input int tgt);
    advance = a; ret = r; call = c; jump = j; skip = s; target = AW'(tgt);
    if (a) begin
      if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = (m_pc + 1) % 256; m_unf = 1'b1; end
      end else if (c) begin
        m_stack.push_back((m_pc + 1) % 256);
        if (m_stack.size() > SD) begin void'(m_stack.pop_front()); m_ovf = 1'b1; end
        m_pc = tgt % 256;
      end else if (j) m_pc = tgt % 256;
      else if (s) m_pc = (m_pc + 2) % 256;
      else m_pc = (m_pc + 1) % 256;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    // Reset then increment through the wrap
    do_reset(2);
    for (int i = 0; i < 260; i++) step("inc", 1, 0, 0, 0, 0, 0);
    check("inc.final_pc", 32'(pc), 32'h04);

    // Nested call/return
    do_reset(1);
    step("nest.jmp", 1, 0, 0, 1, 0, 'h10);
    step("nest.call1", 1, 0, 1, 0, 0, 'h40);
    check("nest.pc1", 32'(pc), 32'h40); check("nest.d1", 32'(depth), 32'd1);
    step("nest.inc", 1, 0, 0, 0, 0, 0);
    step("nest.call2", 1, 0, 1, 0, 0, 'h80);
    check("nest.pc2", 32'(pc), 32'h80); check("nest.d2", 32'(depth), 32'd2);
    step("nest.ret1", 1, 1, 0, 0, 0, 0);
    check("nest.pc3", 32'(pc), 32'h42); check("nest.d3", 32'(depth), 32'd1);
    step("nest.ret2", 1, 1, 0, 0, 0, 0);
    check("nest.pc4", 32'(pc), 32'h11); check("nest.d4", 32'(depth), 32'd0);

    // Overflow then drain into underflow
    do_reset(1);
    for (int i = 0; i < 5; i++) step("ovf.call", 1, 0, 1, 0, 0, 'h20 + i);
    check("ovf.flag", 32'(overflow), 32'd1); check("ovf.depth", 32'(depth), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step("ovf.ret", 1, 1, 0, 0, 0, 0);
      check("ovf.ret_pc", 32'(pc), 32'(8'h24 - 8'(i)));
    end
    step("ovf.ret5", 1, 1, 0, 0, 0, 0);
    check("unf.flag", 32'(underflow), 32'd1); check("unf.pc", 32'(pc), 32'h22);

    // Skip and wrap
    step("skip.jmp", 1, 0, 0, 1, 0, 'hFE);
    check("skip.pc0", 32'(pc), 32'hFE);
    step("skip.s1", 1, 0, 0, 0, 1, 0);
    check("skip.pc1", 32'(pc), 32'h00);
    step("skip.s2", 1, 0, 0, 0, 1, 0);
    check("skip.pc2", 32'(pc), 32'h02);
    step("skip.jmpff", 1, 0, 0, 1, 0, 'hFF);
    step("skip.s3", 1, 0, 0, 0, 1, 0);
    check("skip.pc3", 32'(pc), 32'h01);

    // Priority with all commands together, then a stall with call held
    do_reset(1);
    step("pri.jmp", 1, 0, 0, 1, 0, 'h32);
    step("pri.call", 1, 0, 1, 0, 0, 'h50);
    step("pri.all", 1, 1, 1, 1, 1, 'h77);
    check("pri.pc", 32'(pc), 32'h33); check("pri.depth", 32'(depth), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("hold", 0, 0, 1, 0, 0, 'h99);
      check("hold.pc", 32'(pc), 32'h33);
    end

    // Reset mid-operation with overflow set
    for (int i = 0; i < 7; i++) step("mid.call", 1, 0, 1, 0, 0, 'h60 + i);
    check("mid.ovf", 32'(overflow), 32'd1);
    do_reset(1);
    check("mid.pc", 32'(pc), 32'h00); check("mid.ovf_clr", 32'(overflow), 32'd0);

    // Randomized sequencing against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(249) == 0) do_reset(1);
      else step("rand", $urandom_range(3) != 0, $urandom_range(3) == 0,
                $urandom_range(3) == 0, $urandom_range(4) == 0,
                $urandom_range(3) == 0, int'($urandom_range(255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
